// File: rtl/rsa_pkg.sv
// Op codes, state encodings and default sizing shared by the RSA
// exponentiation sequencer and its helpers.
package rsa_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1024;
  localparam int unsigned DEFAULT_LEN_W = 11;

  typedef enum logic [1:0] {
    OP_TO_MONT   = 2'd0,
    OP_SQUARE    = 2'd1,
    OP_MULT      = 2'd2,
    OP_FROM_MONT = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_WAIT  = 4'd2,
    ST_NEXT  = 4'd3,
    ST_DONE  = 4'd4
  } state_e;

  // Bits needed to address one bit of a w-bit exponent.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rsa_exp_bit_sel.sv
// Latched exponent plus a saturating down-counter that walks it MSB first;
// presents the exponent bit under the counter.
module rsa_exp_bit_sel
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] exp_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic             len_zero_o,
  output logic             is_zero_c,
  output logic             exp_bit_c
);

  localparam int unsigned      IDX_W   = idx_width(WIDTH);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             len_zero_q, len_zero_d;
  logic [LEN_W-1:0] eff_len_c;

  // Lengths beyond the exponent width saturate; the counter never wraps.
  always_comb begin
    eff_len_c  = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    exp_d      = exp_q;
    idx_d      = idx_q;
    len_zero_d = len_zero_q;
    if (load_i) begin
      exp_d      = exp_i;
      idx_d      = IDX_W'(eff_len_c - LEN_W'(1));
      len_zero_d = (eff_len_c == '0);
    end else if (dec_i && (idx_q != '0)) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q      <= '0;
      idx_q      <= '0;
      len_zero_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      len_zero_q <= len_zero_d;
    end
  end

  assign len_zero_o = len_zero_q;
  assign is_zero_c  = (idx_q == '0);
  assign exp_bit_c  = exp_q[idx_q];

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery
// multiplier through a start/done handshake with op codes.
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] exp,
  input  logic [LEN_W-1:0] exp_len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             a_init,
  output logic             mont_start,
  output logic [1:0]       mont_op,
  input  logic             mont_done,
  output logic [3:0]       state_dbg
);

  state_e state_q;
  op_e    op_q;
  op_e    next_op_c;
  logic   busy_q, done_q, error_q, a_init_q, mont_start_q;
  logic   load_c, dec_c, advance_c, finish_c;
  logic   len_zero, is_zero_c, exp_bit_c;

  assign load_c = (state_q == ST_IDLE) && start;

  rsa_exp_bit_sel #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_bit_sel (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_c),
    .exp_i      (exp),
    .len_i      (exp_len),
    .dec_i      (dec_c),
    .len_zero_o (len_zero),
    .is_zero_c  (is_zero_c),
    .exp_bit_c  (exp_bit_c)
  );

  // Next op after the one just completed; index 0 is tested before decrementing.
  always_comb begin
    next_op_c = OP_FROM_MONT;
    advance_c = 1'b0;
    finish_c  = 1'b0;
    case (op_q)
      OP_TO_MONT: next_op_c = len_zero ? OP_FROM_MONT : OP_SQUARE;
      OP_SQUARE:  if (exp_bit_c) next_op_c = OP_MULT; else advance_c = 1'b1;
      OP_MULT:    advance_c = 1'b1;
      default:    finish_c = 1'b1;
    endcase
    if (advance_c && !is_zero_c) next_op_c = OP_SQUARE;
    dec_c = (state_q == ST_NEXT) && advance_c && !is_zero_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_TO_MONT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      a_init_q     <= 1'b0;
      mont_start_q <= 1'b0;
    end else begin
      a_init_q     <= 1'b0;
      mont_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_ISSUE;
            op_q         <= OP_TO_MONT;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
            a_init_q     <= 1'b1;
            mont_start_q <= 1'b1;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT:  if (mont_done) state_q <= ST_NEXT;
        ST_NEXT: begin
          if (finish_c) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q      <= ST_ISSUE;
            op_q         <= next_op_c;
            mont_start_q <= 1'b1;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
      // Stray completions are flagged; placed last so they win over a start's clear.
      if (mont_done && (state_q != ST_WAIT)) error_q <= 1'b1;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign a_init     = a_init_q;
  assign mont_start = mont_start_q;
  assign mont_op    = op_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Scoreboard bench for rsa_exp_ctrl: a bit-walking reference model queues the
// expected op stream, a responder plays the multiplier, a monitor checks.
module tb_rsa_exp_ctrl;
  import rsa_pkg::*;

  localparam int unsigned WIDTH = DEFAULT_WIDTH;
  localparam int unsigned LEN_W = DEFAULT_LEN_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] exp_v;
  logic [LEN_W-1:0] exp_len;
  logic             busy, done, error, a_init, mont_start;
  logic [1:0]       mont_op;
  logic             mont_done;
  logic [3:0]       state_dbg;
  logic             resp_done = 1'b0;
  logic             extra_done = 1'b0;
  logic             inj_done;

  assign mont_done = resp_done | extra_done | inj_done;

  rsa_exp_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .exp        (exp_v),
    .exp_len    (exp_len),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .a_init     (a_init),
    .mont_start (mont_start),
    .mont_op    (mont_op),
    .mont_done  (mont_done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_done_cyc = 0;
  int mstart_cnt = 0;
  int ainit_cnt = 0;
  int done_cnt = 0;
  int run_tag = 0;
  int mon_tag = 0;
  int resp_cnt = 0;
  int resp_lat = 3;
  bit extra_pend = 1'b0;
  bit dbl_mode = 1'b0;
  int err_exp = 0;
  logic [1:0] exp_ops[$];
  logic [1:0] mon_e;
  bit mon_first;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: completes resp_lat cycles after each launch; in dbl_mode
  // it repeats the completion pulse once more (lands while the DUT is in NEXT).
  always @(negedge clk) begin
    resp_done  = 1'b0;
    extra_done = 1'b0;
    if (reset) begin
      resp_cnt   = 0;
      extra_pend = 1'b0;
    end else begin
      if (extra_pend) begin
        extra_done = 1'b1;
        extra_pend = 1'b0;
      end
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_done     = 1'b1;
          last_done_cyc = cyc;
          extra_pend    = dbl_mode;
        end
      end
      if (mont_start) resp_cnt = resp_lat;
    end
  end

  // Monitor: every launch pops one expected op; done closes the run.
  always @(negedge clk) begin
    if (!reset) begin
      if (mont_start) begin
        mstart_cnt++;
        if (exp_ops.size() == 0) begin
          chk("unexpected_mont_start", 1, 0);
        end else begin
          mon_e     = exp_ops.pop_front();
          mon_first = (mon_tag != run_tag);
          mon_tag   = run_tag;
          chk("mont_op", int'(mont_op), int'(mon_e));
          chk("a_init_with_start", int'(a_init), int'(mon_first));
          if (mon_first) chk("start_to_launch", cyc - start_cyc, 1);
          else           chk("done_to_launch", cyc - last_done_cyc, 2);
        end
      end else if (a_init) begin
        chk("a_init_without_start", 1, 0);
      end
      if (a_init) ainit_cnt++;
      if (done) begin
        done_cnt++;
        chk("ops_left_at_done", exp_ops.size(), 0);
        chk("done_latency", cyc - last_done_cyc, 2);
        chk("busy_at_done", int'(busy), 0);
        chk("error_at_done", int'(error), err_exp);
      end
    end
  end

  function automatic logic [WIDTH-1:0] rand_exp();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_a_init"}, int'(a_init), 0);
    chk({tag, "_mont_start"}, int'(mont_start), 0);
    chk({tag, "_mont_op"}, int'(mont_op), 0);
    chk({tag, "_state"}, int'(state_dbg), 0);
  endtask

  // Queue the reference op stream, then pulse start for one cycle.
  task automatic issue(input logic [WIDTH-1:0] e, input int len, input int lat);
    int l;
    l = (len > int'(WIDTH)) ? int'(WIDTH) : len;
    exp_ops.push_back(OP_TO_MONT);
    for (int i = l - 1; i >= 0; i--) begin
      exp_ops.push_back(OP_SQUARE);
      if (e[i]) exp_ops.push_back(OP_MULT);
    end
    exp_ops.push_back(OP_FROM_MONT);
    resp_lat = lat;
    @(negedge clk);
    exp_v     = e;
    exp_len   = LEN_W'(len);
    start     = 1'b1;
    start_cyc = cyc;
    run_tag++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [WIDTH-1:0] e, input int len, input int lat, input bit dup);
    int l, pc, nexp, n0, a0, d0, n, bound;
    l  = (len > int'(WIDTH)) ? int'(WIDTH) : len;
    pc = 0;
    for (int i = 0; i < l; i++) pc += int'(e[i]);
    nexp  = 2 + l + pc;
    bound = nexp * (lat + 3) + 50;
    n0 = mstart_cnt;
    a0 = ainit_cnt;
    d0 = done_cnt;
    issue(e, len, lat);
    chk("error_cleared_by_start", int'(error), 0);
    if (dup) begin
      n = 0;
      while (mstart_cnt < n0 + 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      exp_v   = ~e;
      exp_len = LEN_W'(WIDTH);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("op_count", mstart_cnt - n0, nexp);
    chk("a_init_count", ainit_cnt - a0, 1);
    chk("done_count", done_cnt - d0, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("state_after_done", int'(state_dbg), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] e;
    int n0, n;
    reset    = 1'b1;
    start    = 1'b0;
    exp_v    = '0;
    exp_len  = '0;
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_launch_after_reset", mstart_cnt, 0);

    // Nominal 4'b1011
    e = '0;
    e[3:0] = 4'b1011;
    run(e, 4, 3, 1'b0);

    // Zero length and over-length
    run(rand_exp(), 0, 2, 1'b0);
    run(rand_exp(), int'(WIDTH) + 5, 1, 1'b0);

    // Fast multiplier, all-ones byte
    e = '0;
    e[7:0] = 8'hFF;
    run(e, 8, 1, 1'b0);
    chk("fast_no_error", int'(error), 0);

    // Start while busy must not disturb the running exponent
    e = '0;
    e[3:0] = 4'b1011;
    run(e, 4, 3, 1'b1);

    // Stray completion in IDLE
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("error_after_idle_done", int'(error), 1);
    chk("idle_state_kept", int'(state_dbg), 0);
    chk("idle_busy_kept", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("error_sticky", int'(error), 1);

    // Stray completion in NEXT on every op; sequence must be unaffected
    dbl_mode = 1'b1;
    err_exp  = 1;
    run(rand_exp(), 6, 3, 1'b0);
    dbl_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("error_sticky_after_run", int'(error), 1);
    err_exp = 0;
    run(rand_exp(), 5, 2, 1'b0);

    // Reset during the 4th WAIT
    n0 = mstart_cnt;
    e  = '0;
    e[15:0] = 16'hA5C3;
    issue(e, 16, 3);
    n = 0;
    while (mstart_cnt < n0 + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_4th_launch", int'(mstart_cnt >= n0 + 4), 1);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midop_reset");
    exp_ops.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n0 = mstart_cnt;
    repeat (20) @(negedge clk);
    chk("no_launch_after_midop_reset", mstart_cnt - n0, 0);
    chk("idle_after_midop_reset", int'(state_dbg), 0);
    run(e, 16, 3, 1'b0);

    // Random exponents, lengths and multiplier latencies
    for (int r = 0; r < 6; r++) begin
      run(rand_exp(), int'($urandom_range(0, 48)), int'($urandom_range(1, 5)), 1'b0);
    end
    chk("final_error", int'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
